// File: rtl/mul_operand_feeder.sv
// mul_operand_feeder
//   Streams `count` FP16 operand pairs from two synchronous-read operand
//   memories (A and B) into the multiply stage. Reads are prefetched into a
//   2-entry FIFO, so one pair can move per cycle while the stage stays ready.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   start               command strobe, sampled only when busy=0
//   baseA, baseB        first A / B read address of the command
//   count               number of pairs (0 .. 2^ADDR_W)
//   busy                command in progress (RUN or FIN)
//   done                one-cycle pulse after the last pair is accepted
//   memRd               read enable shared by both memories
//   memA_addr/memB_addr read addresses (wrap modulo 2^ADDR_W)
//   memA_data/memB_data read data, valid the cycle after memRd
//   srcReady            operand pair valid toward the multiply stage
//   readyForInput       multiply stage can accept
//   in_A, in_B          operand pair (FIFO head)
//   fsm_state           current controller state, for observation
//
// Handshake: a pair transfers on every rising edge where srcReady=1 and
// readyForInput=1. Once srcReady is high it stays high, and in_A/in_B stay
// unchanged, until that transfer happens.
module mul_operand_feeder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] baseA,
  input  logic [ADDR_W-1:0] baseB,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              memRd,
  output logic [ADDR_W-1:0] memA_addr,
  output logic [ADDR_W-1:0] memB_addr,
  input  logic [DATA_W-1:0] memA_data,
  input  logic [DATA_W-1:0] memB_data,
  output logic              srcReady,
  input  logic              readyForInput,
  output logic [DATA_W-1:0] in_A,
  output logic [DATA_W-1:0] in_B,
  output logic [1:0]        fsm_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_ZERO = '0;

  logic [1:0]        state;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   issued;
  logic [ADDR_W:0]   accepted;
  logic              inflight;   // a read was issued last cycle; its data lands this edge

  logic [DATA_W-1:0] fifo_a [2];
  logic [DATA_W-1:0] fifo_b [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        occ;

  logic              pop;
  logic              push;
  logic [2:0]        slots_used; // occupancy + in-flight after this cycle's pop

  assign srcReady  = (occ != 2'd0);
  assign in_A      = fifo_a[rd_ptr];
  assign in_B      = fifo_b[rd_ptr];
  assign pop       = srcReady && readyForInput;
  assign push      = inflight;

  // Counting the pop in the same cycle lets a read replace the pair
  // leaving the FIFO, which is what sustains one pair per cycle.
  assign slots_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  assign memRd     = (state == RUN) && (issued < cnt) && (slots_used < 3'd2);
  assign memA_addr = base_a + issued[ADDR_W-1:0];
  assign memB_addr = base_b + issued[ADDR_W-1:0];

  assign busy      = (state == RUN) || (state == FIN);
  assign done      = (state == FIN);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      base_a   <= '0;
      base_b   <= '0;
      cnt      <= '0;
      issued   <= '0;
      accepted <= '0;
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_a[i] <= '0;
        fifo_b[i] <= '0;
      end
    end else begin
      inflight <= memRd;
      if (memRd) begin
        issued <= issued + CNT_ONE;
      end

      if (push) begin
        fifo_a[wr_ptr] <= memA_data;
        fifo_b[wr_ptr] <= memB_data;
        wr_ptr         <= ~wr_ptr;
      end

      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        accepted <= accepted + CNT_ONE;
      end

      occ <= occ + {1'b0, push} - {1'b0, pop};

      case (state)
        IDLE: begin
          if (start) begin
            base_a   <= baseA;
            base_b   <= baseB;
            cnt      <= count;
            issued   <= '0;
            accepted <= '0;
            state    <= (count == CNT_ZERO) ? FIN : RUN;
          end
        end
        RUN: begin
          // Leave on the edge of the final transfer so done follows it directly.
          if (pop && ((accepted + CNT_ONE) == cnt)) begin
            state <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_operand_feeder.sv
// Bench for mul_operand_feeder: memory model, directed commands, and a
// scoreboard monitor that compares every transferred pair and read address.
module tb_mul_operand_feeder;

  localparam int DW = 16;
  localparam int AW = 8;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [AW-1:0] baseA = '0;
  logic [AW-1:0] baseB = '0;
  logic [AW:0]   count = '0;
  logic          busy, done, memRd, srcReady;
  logic [AW-1:0] memA_addr, memB_addr;
  logic [DW-1:0] memA_data, memB_data, in_A, in_B;
  logic          readyForInput = 1'b1;
  logic [1:0]    fsm_state;

  mul_operand_feeder #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .baseA(baseA), .baseB(baseB),
    .count(count), .busy(busy), .done(done), .memRd(memRd),
    .memA_addr(memA_addr), .memB_addr(memB_addr),
    .memA_data(memA_data), .memB_data(memB_data),
    .srcReady(srcReady), .readyForInput(readyForInput),
    .in_A(in_A), .in_B(in_B), .fsm_state(fsm_state)
  );

  // ---------------- operand memories ----------------
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];

  function automatic logic [DW-1:0] exp_a(input logic [7:0] addr);
    return (addr == 8'h10) ? 16'h57B7 : {8'h00, addr};
  endfunction
  function automatic logic [DW-1:0] exp_b(input logic [7:0] addr);
    return (addr == 8'h20) ? 16'hD7B7 : (16'h0100 + {8'h00, addr});
  endfunction

  always @(posedge clk) begin
    if (memRd) begin
      memA_data <= mem_a[memA_addr];
      memB_data <= mem_b[memB_addr];
    end
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q [$];
  logic [15:0] addr_q [$];
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int xfer_cnt = 0, rd_cnt = 0;
  int xfer_total = 0, rd_total = 0;
  int first_xfer_cyc = 0, last_xfer_cyc = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_a = '0, prev_b = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- backpressure driver ----------------
  logic       bp_mode = 1'b0;
  logic [6:0] bp_pat = 7'b1011001;  // bit0 first: 1,0,0,1,1,0,1
  int         bp_idx = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_mode) begin
        readyForInput = bp_pat[bp_idx];
        bp_idx = (bp_idx == 6) ? 0 : bp_idx + 1;
      end else begin
        readyForInput = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      rd_total   = 0;
      xfer_total = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, srcReady}, 32'd1);
        chk("stall_data", {in_A, in_B}, {prev_a, prev_b});
      end
      if (memRd) begin
        rd_cnt++;
        rd_total++;
        if (addr_q.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
        else chk("read_addr", {16'd0, memA_addr, memB_addr}, {16'd0, addr_q.pop_front()});
      end
      if (srcReady && readyForInput) begin
        xfer_cnt++;
        xfer_total++;
        last_xfer_cyc = cyc;
        if (xfer_cnt == 1) first_xfer_cyc = cyc;
        if (exp_q.size() == 0) chk("unexpected_pair", {in_A, in_B}, 32'hxxxxxxxx);
        else chk("pair", {in_A, in_B}, exp_q.pop_front());
      end
      if (memRd) chk("outstanding_le2", {31'd0, (rd_total - xfer_total) <= 2}, 32'd1);
      prev_stall = srcReady && !readyForInput;
      prev_a = in_A;
      prev_b = in_B;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_cmd(input logic [7:0] ba, input logic [7:0] bb, input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] a, b;
      a = ba + 8'(i);
      b = bb + 8'(i);
      exp_q.push_back({exp_a(a), exp_b(b)});
      addr_q.push_back({a, b});
    end
  endtask

  task automatic issue(input logic [7:0] ba, input logic [7:0] bb, input int n);
    @(posedge clk); #1;
    baseA = ba; baseB = bb; count = 9'(n);
    start = 1'b1;
    xfer_cnt = 0; rd_cnt = 0;
    @(posedge clk); #1;  // E0
    start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_memrd"}, {31'd0, memRd}, 32'd0);
    chk({tag, "_addr_a"}, {24'd0, memA_addr}, 32'd0);
    chk({tag, "_addr_b"}, {24'd0, memB_addr}, 32'd0);
    chk({tag, "_srcready"}, {31'd0, srcReady}, 32'd0);
    chk({tag, "_in_ab"}, {in_A, in_B}, 32'd0);
    chk({tag, "_state"}, {30'd0, fsm_state}, 32'd0);
  endtask

  // inject: drive a second start while the command is running
  task automatic run_cmd(input string tag, input logic [7:0] ba, input logic [7:0] bb,
                         input int n, input logic bp, input logic inject);
    int lat;
    bit seen;
    bp_mode = bp;
    push_cmd(ba, bb, n);
    issue(ba, bb, n);
    seen = 0;
    for (lat = 1; lat <= 3000; lat++) begin
      @(negedge clk);
      if (n > 0) begin
        if (lat == 1) chk({tag, "_first_memrd"}, {31'd0, memRd}, 32'd1);
        if (lat == 2) chk({tag, "_src_low_e1"}, {31'd0, srcReady}, 32'd0);
        if (lat == 3) chk({tag, "_src_high_e2"}, {31'd0, srcReady}, 32'd1);
      end
      if (inject && lat == 1) begin
        start = 1'b1; baseA = 8'h77; baseB = 8'h99; count = 9'd3;
      end
      if (inject && lat == 2) start = 1'b0;
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    if (n == 0) chk({tag, "_done_latency"}, lat, 32'd1);
    else chk({tag, "_done_after_last"}, cyc, last_xfer_cyc + 1);
    if (n > 0 && !bp) chk({tag, "_consecutive"}, last_xfer_cyc - first_xfer_cyc, n - 1);
    chk({tag, "_xfers"}, xfer_cnt, n);
    chk({tag, "_reads"}, rd_cnt, n);
    chk({tag, "_queue_empty"}, exp_q.size() + addr_q.size(), 32'd0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, {30'd0, done, busy}, 32'd0);
    bp_mode = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit hit;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = exp_a(8'(i));
      mem_b[i] = exp_b(8'(i));
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    run_cmd("single", 8'h10, 8'h20, 1, 1'b0, 1'b0);
    run_cmd("burst8", 8'h00, 8'h00, 8, 1'b0, 1'b0);
    run_cmd("backpressure", 8'h30, 8'h60, 6, 1'b1, 1'b0);
    run_cmd("wrap", 8'hFE, 8'h03, 4, 1'b0, 1'b0);
    run_cmd("full256", 8'h00, 8'h80, 256, 1'b0, 1'b0);
    run_cmd("zero", 8'h05, 8'h06, 0, 1'b0, 1'b0);
    run_cmd("ignored_start", 8'h40, 8'h50, 4, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("ignored_start_idle", {30'd0, busy, srcReady}, 32'd0);

    // mid-burst reset after the third transfer
    push_cmd(8'h00, 8'h40, 8);
    issue(8'h00, 8'h40, 8);
    hit = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (xfer_cnt == 3) begin
        hit = 1;
        break;
      end
    end
    chk("midreset_reached3", {31'd0, hit}, 32'd1);
    @(posedge clk); #1;   // third transfer edge
    rst = 1'b0;
    @(posedge clk); #1;   // reset sampled here
    rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    check_reset_values("midreset");
    @(negedge clk);
    chk("midreset_no_stale", {31'd0, srcReady}, 32'd0);
    run_cmd("after_reset", 8'h40, 8'h60, 2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
